sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_if.sv | 42 ++++
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sram_arbiter_if
// Purpose : request/ack handshakes and SRAM control pins of the SRAM arbiter
// Rev     : 1.0
// ============================================================================
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              i_wr_req;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ack;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_ack;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_busy;
  logic [ADDR_W-1:0] o_SRAM_ADDR;
  logic              o_SRAM_WE_N;
  logic              o_SRAM_CE_N;
  logic              o_SRAM_OE_N;
  logic              o_SRAM_LB_N;
  logic              o_SRAM_UB_N;

  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    output o_wr_ack, o_rd_ack, o_rd_data, o_busy,
           o_SRAM_ADDR, o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N,
           o_SRAM_LB_N, o_SRAM_UB_N
  );

  modport master (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    input  o_wr_ack, o_rd_ack, o_rd_data, o_busy,
           o_SRAM_ADDR, o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N,
           o_SRAM_LB_N, o_SRAM_UB_N
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sram_arbiter
// Purpose : round-robin sharing of one async 16-bit SRAM between recorder
//           writes and DSP reads; latches address/data at grant
// Rev     : 1.0
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int WR_WAIT = 2,
  parameter int RD_WAIT = 2
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst,
  sram_arbiter_if.slave          bus,
  inout  wire logic [DATA_W-1:0] io_SRAM_DQ
);

  localparam int c_MAX_WAIT = (WR_WAIT > RD_WAIT) ? WR_WAIT : RD_WAIT;
  localparam int c_CNT_W    = (c_MAX_WAIT > 1) ? $clog2(c_MAX_WAIT) : 1;
  localparam logic [c_CNT_W-1:0] c_WR_LAST = c_CNT_W'(WR_WAIT - 1);
  localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(RD_WAIT - 1);
  localparam logic c_GRANT_RD = 1'b0;
  localparam logic c_GRANT_WR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_WR_END = 3'd2,
    S_RD     = 3'd3,
    S_RD_END = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_grant;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_grant_wr;
  logic                w_grant_rd;
  logic                w_rd_capture;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_grant_wr   = 1'b0;
    w_grant_rd   = 1'b0;
    w_rd_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the port that did not win last time goes first
        if (bus.i_wr_req && (!bus.i_rd_req || r_last_grant == c_GRANT_RD)) begin
          w_grant_wr = 1'b1;
          w_next     = S_WR;
        end else if (bus.i_rd_req) begin
          w_grant_rd = 1'b1;
          w_next     = S_RD;
        end
      end
      S_WR:     if (r_cnt == c_WR_LAST) w_next = S_WR_END;
      S_WR_END: w_next = S_IDLE;
      S_RD: begin
        if (r_cnt == c_RD_LAST) begin
          w_next       = S_RD_END;
          w_rd_capture = 1'b1;
        end
      end
      S_RD_END: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= c_GRANT_RD;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd_data    <= '0;
    end else begin
      if (w_grant_wr) begin
        r_last_grant <= c_GRANT_WR;
        r_addr       <= bus.i_wr_addr;
        r_wdata      <= bus.i_wr_data;
      end else if (w_grant_rd) begin
        r_last_grant <= c_GRANT_RD;
        r_addr       <= bus.i_rd_addr;
      end
      if ((r_state == S_WR || r_state == S_RD) && w_next == r_state)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if (w_rd_capture)
        r_rd_data <= io_SRAM_DQ;
    end
  end

  // All strobes and acks decode straight from the state register
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_SRAM_CE_N = (r_state == S_IDLE);
  assign bus.o_SRAM_WE_N = (r_state != S_WR);
  assign bus.o_SRAM_OE_N = (r_state != S_RD);
  assign bus.o_SRAM_LB_N = 1'b0;
  assign bus.o_SRAM_UB_N = 1'b0;
  assign bus.o_wr_ack    = (r_state == S_WR_END);
  assign bus.o_rd_ack    = (r_state == S_RD_END);
  assign bus.o_rd_data   = r_rd_data;
  assign bus.o_SRAM_ADDR = r_addr;

  assign io_SRAM_DQ = (r_state == S_WR || r_state == S_WR_END) ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_sram_arbiter
// Purpose : directed + random handshake traffic against a transaction-timeline
//           reference model and a behavioural SRAM
// Rev     : 1.0
// ============================================================================
module tb_sram_arbiter;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int WR_WAIT = 2;
  localparam int RD_WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  wire [DATA_W-1:0] sram_dq;

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_WAIT(WR_WAIT), .RD_WAIT(RD_WAIT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .io_SRAM_DQ (sram_dq)
  );

  // ---------------- behavioural SRAM (1K words visible) -------------------
  logic [DATA_W-1:0] dev_mem [0:1023];
  logic              dev_drv = 1'b0;
  logic [DATA_W-1:0] dev_q   = '0;
  assign sram_dq = dev_drv ? dev_q : {DATA_W{1'bz}};

  always @(negedge clk) begin
    if (!bus.o_SRAM_CE_N && !bus.o_SRAM_WE_N)
      dev_mem[bus.o_SRAM_ADDR[9:0]] <= sram_dq;
    dev_drv <= !bus.o_SRAM_CE_N && !bus.o_SRAM_OE_N && bus.o_SRAM_WE_N;
    dev_q   <= dev_mem[bus.o_SRAM_ADDR[9:0]];
  end

  function automatic logic [DATA_W-1:0] init_word(input int a);
    logic [15:0] w;
    w = a[15:0];
    return 16'h5A00 ^ w;
  endfunction

  // ---------------- checking ----------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model: one transaction timeline -------------
  // A transaction granted in cycle g is active for offsets 1..WAIT+1 and the
  // arbiter is free again at offset WAIT+2.
  bit                t_valid, t_wr, last_wr, ack_w, ack_r;
  int                g_cyc;
  logic [ADDR_W-1:0] t_addr, m_addr;
  logic [DATA_W-1:0] t_data, m_rd;
  logic [DATA_W-1:0] ref_mem [0:1023];
  int                n_obs_w, n_obs_r, first_obs;

  function automatic int wait_of(input bit wr);
    return wr ? WR_WAIT : RD_WAIT;
  endfunction

  task automatic model_reset;
    t_valid = 1'b0;
    last_wr = 1'b0;
    m_addr  = '0;
    m_rd    = '0;
  endtask

  task automatic model_and_check;
    int k;
    bit act, in_wait;
    ack_w = 1'b0;
    ack_r = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (t_valid && cyc >= g_cyc + wait_of(t_wr) + 2) begin
        t_valid = 1'b0;
        m_addr  = t_addr;
      end
      if (!t_valid && (bus.i_wr_req || bus.i_rd_req)) begin
        t_wr    = bus.i_wr_req && (!bus.i_rd_req || !last_wr);
        t_valid = 1'b1;
        g_cyc   = cyc;
        last_wr = t_wr;
        t_addr  = t_wr ? bus.i_wr_addr : bus.i_rd_addr;
        t_data  = bus.i_wr_data;
      end
    end
    k       = cyc - g_cyc;
    act     = t_valid && k >= 1;
    in_wait = act && k <= wait_of(t_wr);
    if (act && k == wait_of(t_wr) + 1) begin
      if (t_wr) begin ack_w = 1'b1; ref_mem[t_addr[9:0]] = t_data; end
      else      begin ack_r = 1'b1; m_rd = ref_mem[t_addr[9:0]];   end
    end
    check_eq("busy",    {31'd0, bus.o_busy},      {31'd0, act});
    check_eq("ce_n",    {31'd0, bus.o_SRAM_CE_N}, {31'd0, !act});
    check_eq("we_n",    {31'd0, bus.o_SRAM_WE_N}, {31'd0, !(in_wait && t_wr)});
    check_eq("oe_n",    {31'd0, bus.o_SRAM_OE_N}, {31'd0, !(in_wait && !t_wr)});
    check_eq("wr_ack",  {31'd0, bus.o_wr_ack},    {31'd0, ack_w});
    check_eq("rd_ack",  {31'd0, bus.o_rd_ack},    {31'd0, ack_r});
    check_eq("rd_data", 32'(bus.o_rd_data),       32'(m_rd));
    check_eq("addr",    32'(bus.o_SRAM_ADDR),     32'(act ? t_addr : m_addr));
    check_eq("lb_ub",   {30'd0, bus.o_SRAM_LB_N, bus.o_SRAM_UB_N}, 32'd0);
    if (act && t_wr) check_eq("dq_wr", 32'(sram_dq), 32'(t_data));
    if (bus.o_wr_ack) begin n_obs_w++; if (first_obs == 0) first_obs = 1; end
    if (bus.o_rd_ack) begin n_obs_r++; if (first_obs == 0) first_obs = 2; end
  endtask

  // ---------------- requesters --------------------------------------------
  bit rand_mode = 1'b0;
  bit auto_drop = 1'b1;

  function automatic logic [ADDR_W-1:0] rnd_addr();
    return ADDR_W'($urandom_range(0, 63));
  endfunction

  task automatic agent;
    if (ack_w && auto_drop) begin
      if (rand_mode && $urandom_range(0, 3) == 0) begin
        bus.i_wr_addr = rnd_addr();
        bus.i_wr_data = DATA_W'($urandom);
      end else bus.i_wr_req = 1'b0;
    end else if (rand_mode) begin
      if (!bus.i_wr_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.i_wr_req  = 1'b1;
          bus.i_wr_addr = rnd_addr();
          bus.i_wr_data = DATA_W'($urandom);
        end
      end else if (t_valid && t_wr) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.i_wr_addr = rnd_addr();
          bus.i_wr_data = DATA_W'($urandom);
        end
        if ($urandom_range(0, 7) == 0) bus.i_wr_req = 1'b0;
      end
    end
    if (ack_r && auto_drop) begin
      if (rand_mode && $urandom_range(0, 3) == 0) bus.i_rd_addr = rnd_addr();
      else bus.i_rd_req = 1'b0;
    end else if (rand_mode) begin
      if (!bus.i_rd_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.i_rd_req  = 1'b1;
          bus.i_rd_addr = rnd_addr();
        end
      end else if (t_valid && !t_wr) begin
        if ($urandom_range(0, 3) == 0) bus.i_rd_addr = rnd_addr();
        if ($urandom_range(0, 7) == 0) bus.i_rd_req = 1'b0;
      end
    end
  endtask

  task automatic step;
    @(negedge clk);
    model_and_check();
    @(posedge clk);
    #1;
    cyc++;
    agent();
  endtask

  task automatic clear_obs;
    n_obs_w = 0; n_obs_r = 0; first_obs = 0;
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    dev_mem[32] = 16'h1234;
    ref_mem[32] = 16'h1234;
    bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;
    model_reset();
    clear_obs();

    // reset held three cycles
    repeat (3) step();
    check_eq("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
    check_eq("rst_strobes", {29'd0, bus.o_SRAM_WE_N, bus.o_SRAM_OE_N, bus.o_SRAM_CE_N}, 32'd7);
    rst = 1'b0;
    step();

    // single write
    clear_obs();
    bus.i_wr_addr = 20'h00010; bus.i_wr_data = 16'hABCD; bus.i_wr_req = 1'b1;
    repeat (6) step();
    check_eq("single_wr_acks", 32'(n_obs_w), 32'd1);
    check_eq("single_wr_mem", 32'(dev_mem[16]), 32'h0000ABCD);

    // inputs change right after grant; SRAM must see the latched values
    bus.i_wr_addr = 20'h00011; bus.i_wr_data = 16'h5678; bus.i_wr_req = 1'b1;
    step();
    bus.i_wr_addr = 20'h99999; bus.i_wr_data = 16'h1111;
    repeat (5) step();
    check_eq("latched_mem", 32'(dev_mem[17]), 32'h00005678);
    check_eq("unlatched_mem", 32'(dev_mem[10'h199]), 32'(init_word(32'h199)));

    // single read, value held after ack
    clear_obs();
    bus.i_rd_addr = 20'h00020; bus.i_rd_req = 1'b1;
    repeat (8) step();
    check_eq("single_rd_acks", 32'(n_obs_r), 32'd1);
    check_eq("rd_hold", 32'(bus.o_rd_data), 32'h00001234);

    // saturated: both requests held through ten transactions after reset
    rst = 1'b1;
    repeat (2) step();
    bus.i_wr_addr = 20'h00030; bus.i_wr_data = 16'hC0DE; bus.i_wr_req = 1'b1;
    bus.i_rd_addr = 20'h00010; bus.i_rd_req = 1'b1;
    auto_drop = 1'b0;
    rst = 1'b0;
    clear_obs();
    repeat (40) step();
    bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
    auto_drop = 1'b1;
    check_eq("sat_wr_count", 32'(n_obs_w), 32'd5);
    check_eq("sat_rd_count", 32'(n_obs_r), 32'd5);
    check_eq("sat_first_wr", 32'(first_obs), 32'd1);
    repeat (2) step();

    // reset in the second write cycle: strobes drop at once, no ack
    clear_obs();
    bus.i_wr_addr = 20'h003FF; bus.i_wr_data = 16'hDEAD; bus.i_wr_req = 1'b1;
    repeat (2) step();
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_we_n", {31'd0, bus.o_SRAM_WE_N}, 32'd1);
    check_eq("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    check_eq("midrst_ack", {31'd0, bus.o_wr_ack}, 32'd0);
    step();
    bus.i_wr_addr = 20'h00005; bus.i_wr_data = 16'h0F0F;
    bus.i_rd_addr = 20'h00011; bus.i_rd_req = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    check_eq("midrst_first_wr", 32'(first_obs), 32'd1);
    check_eq("midrst_counts", 32'(n_obs_w * 16 + n_obs_r), 32'h11);

    // randomized traffic
    rand_mode = 1'b1;
    repeat (3000) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
